crossbar_2x2_sched: RTL

//  Front-end scheduler for the 2x2 crossbar: two valid/ready input ports each carry a WIDTH-bit word plus a

---
 rtl/crossbar_pkg.sv | 14 +
 rtl/rr_arbiter_2.sv | 28 ++
 rtl/crossbar_2x2_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/crossbar_pkg.sv
// Shared constants for the 2x2 crossbar scheduler: switch settings and destination encodings.
package crossbar_pkg;

    localparam logic CTRL_STRAIGHT = 1'b0;
    localparam logic CTRL_CROSS    = 1'b1;
    localparam logic DEST_OUT0     = 1'b0;
    localparam logic DEST_OUT1     = 1'b1;

    // Setting implied by a single routed word: straight when source index equals destination.
    function automatic logic route_setting(input logic src, input logic dest);
        return (src == dest) ? CTRL_STRAIGHT : CTRL_CROSS;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter; the priority flop moves to the loser when advance is pulsed.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_prio;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = r_prio ? 2'b10 : 2'b01;
        end
    end

    // With two requesters, handing priority to the loser is a plain toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (advance) begin
            r_prio <= ~r_prio;
        end
    end

endmodule

// File: rtl/crossbar_2x2_sched.sv
// 2x2 crossbar front-end: grants inputs to single-word output slots, round-robin on conflicts,
// tracks the applied switch setting and a saturating conflict count.
module crossbar_2x2_sched
    import crossbar_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_dest,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_dest,
    output logic             in1_ready,
    output logic             out0_valid,
    output logic [WIDTH-1:0] out0_data,
    input  logic             out0_ready,
    output logic             out1_valid,
    output logic [WIDTH-1:0] out1_data,
    input  logic             out1_ready,
    output logic             control,
    output logic [CNT_W-1:0] conflict_cnt
);

    logic [1:0]       r_valid;
    logic [WIDTH-1:0] r_data0;
    logic [WIDTH-1:0] r_data1;
    logic             r_control;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0] w_out_ready;
    logic [1:0] w_slot_free;
    logic [1:0] w_take0;
    logic [1:0] w_take1;
    logic [1:0] w_arb_grant;
    logic       w_conflict;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_acc0;
    logic       w_acc1;
    logic       w_advance;

    assign w_out_ready = {out1_ready, out0_ready};
    assign w_conflict  = in0_valid & in1_valid & (in0_dest == in1_dest);

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({in1_valid, in0_valid}),
        .advance (w_advance),
        .grant   (w_arb_grant)
    );

    // The arbiter only decides on conflict; non-conflicting valid inputs are always granted.
    assign w_grant0 = in0_valid & (~w_conflict | w_arb_grant[0]);
    assign w_grant1 = in1_valid & (~w_conflict | w_arb_grant[1]);

    // Ready depends combinationally on downstream ready (same-cycle drain, no bubble).
    assign in0_ready = w_grant0 & w_slot_free[in0_dest];
    assign in1_ready = w_grant1 & w_slot_free[in1_dest];
    assign w_acc0    = in0_valid & in0_ready;
    assign w_acc1    = in1_valid & in1_ready;
    assign w_advance = w_conflict & (w_acc0 | w_acc1);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign w_slot_free[gi] = ~r_valid[gi] | w_out_ready[gi];
            assign w_take0[gi]     = w_acc0 & (in0_dest == 1'(gi));
            assign w_take1[gi]     = w_acc1 & (in1_dest == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 2'b00;
            r_data0 <= '0;
            r_data1 <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_take0[i] | w_take1[i]) begin
                    r_valid[i] <= 1'b1;
                end else if (w_out_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (w_take0[0]) begin
                r_data0 <= in0_data;
            end else if (w_take1[0]) begin
                r_data0 <= in1_data;
            end
            if (w_take0[1]) begin
                r_data1 <= in0_data;
            end else if (w_take1[1]) begin
                r_data1 <= in1_data;
            end
        end
    end

    // Two simultaneous accepts always imply the same setting, so in0 can take precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_control <= CTRL_STRAIGHT;
        end else if (w_acc0) begin
            r_control <= route_setting(1'b0, in0_dest);
        end else if (w_acc1) begin
            r_control <= route_setting(1'b1, in1_dest);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_advance && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out0_valid   = r_valid[0];
    assign out1_valid   = r_valid[1];
    assign out0_data    = r_data0;
    assign out1_data    = r_data1;
    assign control      = r_control;
    assign conflict_cnt = r_cnt;

endmodule
